// File: rtl/motor_pkg.sv
// Shared definitions for the motor duty scheduler.
// Holds the duty width, the default duty clamp and the scheduler state encoding.
package motor_pkg;

    localparam int DUTY_W       = 8;
    localparam int MAX_DUTY_DEF = 100;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage : motor_pkg

// File: rtl/motor_duty_sched_tick_gen.sv
// Ramp tick generator: a reloading down-counter that emits one pulse every RAMP_DIV cycles.
// Asserting clr restarts the period, so the first tick comes RAMP_DIV cycles after clr.
module tick_gen #(
    parameter int RAMP_DIV = 50000
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(RAMP_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || (cnt == '0)) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // Terminal count of the period; a clear in the same cycle wins.
    assign tick = !clr && (cnt == '0);

endmodule : tick_gen

// File: rtl/motor_duty_sched.sv
// Round-robin duty scheduler: grants one of two requesters a new duty target and ramps
// duty_out toward it in fixed steps, one step per tick, with an emergency-stop override.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no ramp active; a request (estop low) is granted this cycle
//  RAMP  | stepping duty_out toward target on each tick; done on match
module motor_duty_sched
    import motor_pkg::*;
#(
    parameter int RAMP_DIV = 50000,
    parameter int STEP     = 5,
    parameter int MAX_DUTY = MAX_DUTY_DEF
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [DUTY_W-1:0] duty_a,
    input  logic              req_b,
    input  logic [DUTY_W-1:0] duty_b,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty_out,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              busy,
    output logic              done
);

    localparam logic [DUTY_W:0] STEP9 = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W:0] MAX9  = (DUTY_W + 1)'(MAX_DUTY);

    state_t            state;
    state_t            state_nxt;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] target_nxt;
    logic [DUTY_W-1:0] duty_nxt;
    logic              last_b;
    logic              last_b_nxt;
    logic              pick_a;
    logic              grant_ok;
    logic              tick;
    logic              tick_clr;

    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d);
        if ({1'b0, d} > MAX9) begin
            return MAX9[DUTY_W-1:0];
        end
        return d;
    endfunction

    // One step toward tgt in 9-bit arithmetic, landing exactly on tgt rather than overshooting.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                       input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W:0] up;
        logic [DUTY_W:0] dn;
        up = {1'b0, cur} + STEP9;
        dn = {1'b0, cur} - STEP9;
        if (cur < tgt) begin
            return (up > {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
        end else if (cur > tgt) begin
            if (({1'b0, cur} < STEP9) || (dn < {1'b0, tgt})) begin
                return tgt;
            end
            return dn[DUTY_W-1:0];
        end
        return cur;
    endfunction

    tick_gen #(
        .RAMP_DIV (RAMP_DIV)
    ) u_tick_gen (
        .clk_50 (clk_50),
        .rst_n  (rst_n),
        .clr    (tick_clr),
        .tick   (tick)
    );

    // A wins when alone, or on a tie when B was granted last.
    assign pick_a   = req_a && (!req_b || last_b);
    // Grants are combinational, so they are also masked by reset to stay low during it.
    assign grant_ok = rst_n && (state == IDLE) && !estop;
    assign gnt_a    = grant_ok && pick_a;
    assign gnt_b    = grant_ok && req_b && !pick_a;
    assign busy     = (state == RAMP);
    assign done     = (state == RAMP) && !estop && (duty_out == target);

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= '0;
            duty_out <= '0;
            last_b   <= 1'b1;
        end else begin
            state    <= state_nxt;
            target   <= target_nxt;
            duty_out <= duty_nxt;
            last_b   <= last_b_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        duty_nxt   = duty_out;
        last_b_nxt = last_b;
        tick_clr   = 1'b0;

        if (estop) begin
            state_nxt  = IDLE;
            target_nxt = '0;
            duty_nxt   = '0;
            tick_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_a) begin
                        target_nxt = clamp_duty(duty_a);
                        last_b_nxt = 1'b0;
                        state_nxt  = RAMP;
                        tick_clr   = 1'b1;
                    end else if (gnt_b) begin
                        target_nxt = clamp_duty(duty_b);
                        last_b_nxt = 1'b1;
                        state_nxt  = RAMP;
                        tick_clr   = 1'b1;
                    end
                end
                RAMP: begin
                    if (done) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        duty_nxt = step_toward(duty_out, target);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule : motor_duty_sched

// File: doc/motor_duty_sched.md
MOTOR_DUTY_SCHED -- requirements
Module: motor_duty_sched

Interface
REQ-001 The block SHALL have parameter RAMP_DIV, default 50000, meaning clk_50 cycles per ramp tick (1 ms at 50 MHz).
REQ-002 The block SHALL have parameter STEP, default 5, meaning duty change per tick in percent.
REQ-003 The block SHALL have parameter MAX_DUTY, default 100, meaning the upper clamp for any duty value.
REQ-004 The block SHALL have port clk_50 input 1: the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req_a input 1: requester A asks for a duty change, held until gnt_a.
REQ-007 The block SHALL have port duty_a input 8: requester A target duty in percent, sampled in the gnt_a cycle.
REQ-008 The block SHALL have port req_b input 1: requester B request, held until gnt_b.
REQ-009 The block SHALL have port duty_b input 8: requester B target duty in percent, sampled in the gnt_b cycle.
REQ-010 The block SHALL have port estop input 1: synchronous emergency stop, level-sensitive.
REQ-011 The block SHALL have port duty_out output 8: duty in percent (0..MAX_DUTY) driving the PWM generator's duty input.
REQ-012 The block SHALL have ports gnt_a and gnt_b output 1 each: one-cycle grant pulses.
REQ-013 The block SHALL have port busy output 1: high while a ramp is in progress.
REQ-014 The block SHALL have port done output 1: one-cycle pulse when duty_out reaches the granted target.

Function
REQ-015 The state machine SHALL have states IDLE and RAMP only.
REQ-016 In IDLE with estop low and any request high, the block SHALL pulse exactly one grant and enter RAMP on the next edge.
REQ-017 Arbitration SHALL be round-robin: on a simultaneous req_a and req_b, the requester not granted last wins.
REQ-018 On grant, target SHALL be loaded as min(duty_x, MAX_DUTY); a duty_x above MAX_DUTY is clamped, not rejected.
REQ-019 In RAMP, the tick counter SHALL restart at grant, so the first step lands RAMP_DIV cycles after entering RAMP.
REQ-020 On each tick: if duty_out < target, duty_out SHALL become min(duty_out+STEP, target); if greater, max(duty_out-STEP, target).
REQ-021 Arithmetic SHALL be 9-bit internally so that no step wraps below 0 or above 255.
REQ-022 When duty_out equals target in RAMP, the block SHALL pulse done for one cycle and return to IDLE; if equal at grant, done pulses on the first RAMP cycle without waiting for a tick.
REQ-023 Requests arriving in RAMP SHALL NOT be granted until IDLE; gnt_a and gnt_b SHALL never be high together.
REQ-024 busy SHALL equal (state == RAMP).
REQ-025 estop high SHALL, on the next edge, force duty_out=0, target=0, and state=IDLE, suppress done, and block all grants while high; this takes priority over ticks and grants in the same cycle.
REQ-026 After estop falls, a pending request SHALL be granted on the first IDLE cycle.

Reset
REQ-027 While rst_n is low, duty_out=0, target=0, gnt_a=gnt_b=0, done=0, busy=0, state=IDLE, and tick counter=0.
REQ-028 The round-robin pointer SHALL reset to "B granted last", so A wins the first tie.
REQ-029 Reset asserted mid-ramp SHALL abandon the ramp immediately, with no done pulse.

Structure
REQ-030 Shared package motor_pkg SHALL hold the MAX_DUTY default, the DUTY_W=8 width, and the state enum (IDLE, RAMP).
REQ-031 Tick generation SHALL be a sub-module tick_gen (parameter RAMP_DIV, inputs clk_50, rst_n, clr; output tick one-cycle pulse).

Verification (RAMP_DIV=4, STEP=5)
REQ-032 Reset, then req_a=1 with duty_a=20 -> gnt_a 1 cycle; duty_out 5,10,15,20 every 4 cycles; done pulses once; busy falls.
REQ-033 duty_out=20, req_b=1 with duty_b=7 -> steps 15,10,7; the last step clamps at target; done pulses once.
REQ-034 req_a and req_b rise together after reset -> gnt_a first; after done, gnt_b; the next tie goes to A.
REQ-035 duty_a=150 -> target clamps to 100; ramp ends at 100 with no wrap; duty_a=duty_out -> done on the first RAMP cycle.
REQ-036 estop raised mid-ramp at duty 35 -> duty_out=0 next cycle, busy=0, no done; held req_b is granted on the first cycle after estop falls.
REQ-037 rst_n pulsed low mid-ramp -> all outputs 0 asynchronously; a later tie is granted to A.
